// File: rtl/dp_ram_be.sv
// True dual-port RAM with per-byte write enables, same-cycle write-to-read
// forwarding across ports, and a 1- or 2-stage registered read pipeline.
module dp_ram_be #(
  parameter int DPRAM_AW = 4,
  parameter int DPRAM_DW = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cyc_a_i,
  input  logic                  we_a_i,
  input  logic [DPRAM_DW/8-1:0] be_a_i,
  input  logic [DPRAM_AW-1:0]   adr_a_i,
  input  logic [DPRAM_DW-1:0]   dat_a_i,
  output logic [DPRAM_DW-1:0]   dat_a_o,
  output logic                  vld_a_o,
  input  logic                  cyc_b_i,
  input  logic                  we_b_i,
  input  logic [DPRAM_DW/8-1:0] be_b_i,
  input  logic [DPRAM_AW-1:0]   adr_b_i,
  input  logic [DPRAM_DW-1:0]   dat_b_i,
  output logic [DPRAM_DW-1:0]   dat_b_o,
  output logic                  vld_b_o
);

  localparam int NB    = DPRAM_DW / 8;
  localparam int DEPTH = 2 ** DPRAM_AW;

  // Contents survive reset; zero only at elaboration.
  logic [DPRAM_DW-1:0] mem [DEPTH] = '{default: '0};

  logic                wr_a, wr_b, rd_a, rd_b, same_adr;
  logic [NB-1:0]       keep_a, keep_b;
  logic [DPRAM_DW-1:0] fwd_a, fwd_b;

  always_comb begin
    wr_a     = rst_n & cyc_a_i & we_a_i & (|be_a_i);
    wr_b     = rst_n & cyc_b_i & we_b_i & (|be_b_i);
    rd_a     = rst_n & cyc_a_i & ~we_a_i;
    rd_b     = rst_n & cyc_b_i & ~we_b_i;
    same_adr = (adr_a_i == adr_b_i);
    keep_a   = wr_a ? be_a_i : '0;
    keep_b   = wr_b ? be_b_i : '0;
    // Overlapping bytes of a same-address double write go to the priority port.
    if (wr_a && wr_b && same_adr) begin
      if (WR_PRIO == 0) keep_b = be_b_i & ~be_a_i;
      else              keep_a = be_a_i & ~be_b_i;
    end
    fwd_a = mem[adr_a_i];
    fwd_b = mem[adr_b_i];
    for (int k = 0; k < NB; k++) begin
      if (wr_b && same_adr && be_b_i[k]) fwd_a[8*k +: 8] = dat_b_i[8*k +: 8];
      if (wr_a && same_adr && be_a_i[k]) fwd_b[8*k +: 8] = dat_a_i[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (keep_a[k]) mem[adr_a_i][8*k +: 8] <= dat_a_i[8*k +: 8];
      if (keep_b[k]) mem[adr_b_i][8*k +: 8] <= dat_b_i[8*k +: 8];
    end
  end

  // vld_*_o is a one-cycle strobe with no backpressure; data registers only
  // load on a valid stage so the outputs hold the last read between strobes.
  logic                v1_a, v1_b;
  logic [DPRAM_DW-1:0] d1_a, d1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_a <= 1'b0;
      v1_b <= 1'b0;
      d1_a <= '0;
      d1_b <= '0;
    end else begin
      v1_a <= rd_a;
      v1_b <= rd_b;
      if (rd_a) d1_a <= fwd_a;
      if (rd_b) d1_b <= fwd_b;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic                v2_a, v2_b;
      logic [DPRAM_DW-1:0] d2_a, d2_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_a <= 1'b0;
          v2_b <= 1'b0;
          d2_a <= '0;
          d2_b <= '0;
        end else begin
          v2_a <= v1_a;
          v2_b <= v1_b;
          if (v1_a) d2_a <= d1_a;
          if (v1_b) d2_b <= d1_b;
        end
      end

      assign vld_a_o = v2_a;
      assign vld_b_o = v2_b;
      assign dat_a_o = d2_a;
      assign dat_b_o = d2_b;
    end else begin : g_lat1
      assign vld_a_o = v1_a;
      assign vld_b_o = v1_b;
      assign dat_a_o = d1_a;
      assign dat_b_o = d1_b;
    end
  endgenerate

endmodule

// File: tb/tb_dp_ram_be.sv
// Bench for dp_ram_be: two instances (RD_LAT=1/WR_PRIO=0 and RD_LAT=2/WR_PRIO=1)
// share stimulus; each output port has its own expected queue keyed by due cycle.
module tb_dp_ram_be;

  logic        clk;
  logic        rst_n;
  logic        cyc_a_i, we_a_i, cyc_b_i, we_b_i;
  logic [3:0]  be_a_i, be_b_i, adr_a_i, adr_b_i;
  logic [31:0] dat_a_i, dat_b_i;
  logic [31:0] dat_a0, dat_b0, dat_a1, dat_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1;

  dp_ram_be #(.DPRAM_AW(4), .DPRAM_DW(32), .RD_LAT(1), .WR_PRIO(0)) dut_p0 (
    .clk(clk), .rst_n(rst_n),
    .cyc_a_i(cyc_a_i), .we_a_i(we_a_i), .be_a_i(be_a_i), .adr_a_i(adr_a_i),
    .dat_a_i(dat_a_i), .dat_a_o(dat_a0), .vld_a_o(vld_a0),
    .cyc_b_i(cyc_b_i), .we_b_i(we_b_i), .be_b_i(be_b_i), .adr_b_i(adr_b_i),
    .dat_b_i(dat_b_i), .dat_b_o(dat_b0), .vld_b_o(vld_b0)
  );

  dp_ram_be #(.DPRAM_AW(4), .DPRAM_DW(32), .RD_LAT(2), .WR_PRIO(1)) dut_p1 (
    .clk(clk), .rst_n(rst_n),
    .cyc_a_i(cyc_a_i), .we_a_i(we_a_i), .be_a_i(be_a_i), .adr_a_i(adr_a_i),
    .dat_a_i(dat_a_i), .dat_a_o(dat_a1), .vld_a_o(vld_a1),
    .cyc_b_i(cyc_b_i), .we_b_i(we_b_i), .be_b_i(be_b_i), .adr_b_i(adr_b_i),
    .dat_b_i(dat_b_i), .dat_b_o(dat_b1), .vld_b_o(vld_b1)
  );

  typedef struct {
    logic        cyc_a, we_a;
    logic [3:0]  be_a, adr_a;
    logic [31:0] dat_a;
    logic        cyc_b, we_b;
    logic [3:0]  be_b, adr_b;
    logic [31:0] dat_b;
    logic [31:0] ea0, ea1, eb0, eb1;
  } row_t;

  // index: 0 = p0/A, 1 = p0/B, 2 = p1/A, 3 = p1/B; entry = {due_cycle, data}
  logic [63:0] exp_q [4][$];
  logic [31:0] last_dat [4];
  logic [31:0] m [2][16];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc_n  = 0;
  row_t        tbl[$];
  row_t        idle;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // ---------------- helpers ----------------
  function automatic row_t mk(input logic ca, wa, input logic [3:0] ba, aa,
                              input logic [31:0] da,
                              input logic cb, wb, input logic [3:0] bb, ab,
                              input logic [31:0] db,
                              input logic [31:0] ea0, ea1, eb0, eb1);
    row_t r;
    r.cyc_a = ca; r.we_a = wa; r.be_a = ba; r.adr_a = aa; r.dat_a = da;
    r.cyc_b = cb; r.we_b = wb; r.be_b = bb; r.adr_b = ab; r.dat_b = db;
    r.ea0 = ea0; r.ea1 = ea1; r.eb0 = eb0; r.eb1 = eb1;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, need %08h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  task automatic flush_exp();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_row(input row_t r, input bit use_tbl);
    logic [31:0] pa, pb;
    logic        wa, wb;
    cyc_a_i = r.cyc_a; we_a_i = r.we_a; be_a_i = r.be_a; adr_a_i = r.adr_a; dat_a_i = r.dat_a;
    cyc_b_i = r.cyc_b; we_b_i = r.we_b; be_b_i = r.be_b; adr_b_i = r.adr_b; dat_b_i = r.dat_b;
    if (rst_n) begin
      wa = r.cyc_a & r.we_a & (|r.be_a);
      wb = r.cyc_b & r.we_b & (|r.be_b);
      for (int p = 0; p < 2; p++) begin
        pa = m[p][r.adr_a];
        pb = m[p][r.adr_b];
        for (int k = 0; k < 4; k++) begin
          if (wb && r.adr_b == r.adr_a && r.be_b[k]) pa[8*k +: 8] = r.dat_b[8*k +: 8];
          if (wa && r.adr_a == r.adr_b && r.be_a[k]) pb[8*k +: 8] = r.dat_a[8*k +: 8];
        end
        if (r.cyc_a && !r.we_a)
          exp_q[2*p].push_back({32'(cyc_n + p + 1), use_tbl ? (p == 0 ? r.ea0 : r.ea1) : pa});
        if (r.cyc_b && !r.we_b)
          exp_q[2*p+1].push_back({32'(cyc_n + p + 1), use_tbl ? (p == 0 ? r.eb0 : r.eb1) : pb});
      end
      // model writes: the losing port is applied first so the winner lands last
      for (int k = 0; k < 4; k++) begin
        if (wb && r.be_b[k]) m[0][r.adr_b][8*k +: 8] = r.dat_b[8*k +: 8];
        if (wa && r.be_a[k]) m[0][r.adr_a][8*k +: 8] = r.dat_a[8*k +: 8];
        if (wa && r.be_a[k]) m[1][r.adr_a][8*k +: 8] = r.dat_a[8*k +: 8];
        if (wb && r.be_b[k]) m[1][r.adr_b][8*k +: 8] = r.dat_b[8*k +: 8];
      end
    end
  endtask

  task automatic step(input row_t r, input bit use_tbl);
    @(posedge clk);
    #1;
    drive_row(r, use_tbl);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check_port(input int idx, input logic vld, input logic [31:0] dat);
    logic [63:0] e;
    if (!rst_n) begin
      cmp($sformatf("rst_vld[%0d]", idx), {31'b0, vld}, 32'h0);
      cmp($sformatf("rst_dat[%0d]", idx), dat, 32'h0);
      last_dat[idx] = '0;
      return;
    end
    if (vld === 1'b1) begin
      if (exp_q[idx].size() == 0 || exp_q[idx][0][63:32] != 32'(cyc_n)) begin
        n_cmp++;
        n_fail++;
        $display("FAIL vld_unexpected[%0d]: got vld=1, need vld=0 (cycle %0d)", idx, cyc_n);
      end else begin
        e = exp_q[idx].pop_front();
        cmp($sformatf("rd_data[%0d]", idx), dat, e[31:0]);
      end
      last_dat[idx] = dat;
    end else begin
      cmp($sformatf("hold[%0d]", idx), dat, last_dat[idx]);
      if (exp_q[idx].size() > 0 && exp_q[idx][0][63:32] <= 32'(cyc_n)) begin
        e = exp_q[idx].pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL vld_missing[%0d]: got vld=%b, need vld=1 with %08h (cycle %0d)",
                 idx, vld, e[31:0], cyc_n);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check_port(0, vld_a0, dat_a0);
      check_port(1, vld_b0, dat_b0);
      check_port(2, vld_a1, dat_a1);
      check_port(3, vld_b1, dat_b1);
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    idle  = mk(0,0,4'h0,4'h0,32'h0, 0,0,4'h0,4'h0,32'h0, 0,0,0,0);
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 16; a++) m[p][a] = '0;
    for (int i = 0; i < 4; i++) last_dat[i] = '0;
    drive_row(idle, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // directed table: inputs plus expected read data for (p0, p1)
    tbl.push_back(mk(1,0,4'h0,4'd3,32'h0,        0,0,4'h0,4'd0,32'h0,        32'h0,32'h0,32'h0,32'h0));
    tbl.push_back(mk(1,1,4'h5,4'd5,32'hAABBCCDD, 0,0,4'h0,4'd0,32'h0,        0,0,0,0));
    tbl.push_back(mk(0,0,4'h0,4'd0,32'h0,        1,0,4'h0,4'd5,32'h0,        0,0,32'h00BB00DD,32'h00BB00DD));
    tbl.push_back(mk(1,1,4'h3,4'd2,32'h11223344, 1,0,4'h0,4'd2,32'h0,        0,0,32'h00003344,32'h00003344));
    tbl.push_back(mk(1,1,4'hC,4'd7,32'hAAAAAAAA, 1,1,4'h6,4'd7,32'hBBBBBBBB, 0,0,0,0));
    tbl.push_back(mk(1,0,4'h0,4'd7,32'h0,        0,0,4'h0,4'd0,32'h0,        32'hAAAABB00,32'hAABBBB00,0,0));
    tbl.push_back(mk(1,1,4'h0,4'd2,32'hFFFFFFFF, 1,0,4'h0,4'd2,32'h0,        0,0,32'h00003344,32'h00003344));
    tbl.push_back(mk(1,0,4'h0,4'd2,32'h0,        1,1,4'h8,4'd2,32'h99000000, 32'h99003344,32'h99003344,0,0));
    tbl.push_back(mk(1,0,4'h0,4'd2,32'h0,        1,0,4'h0,4'd5,32'h0,        32'h99003344,32'h99003344,32'h00BB00DD,32'h00BB00DD));
    tbl.push_back(mk(1,1,4'hF,4'd4,32'h12345678, 1,0,4'h0,4'd4,32'h0,        0,0,32'h12345678,32'h12345678));
    tbl.push_back(idle);
    tbl.push_back(mk(1,0,4'h1,4'd4,32'h0,        1,0,4'h0,4'd4,32'h0,        32'h12345678,32'h12345678,32'h12345678,32'h12345678));
    tbl.push_back(mk(0,0,4'h0,4'd0,32'h0,        1,1,4'hF,4'd4,32'h0,        0,0,0,0));
    tbl.push_back(mk(1,0,4'h0,4'd4,32'h0,        1,0,4'hF,4'd7,32'h0,        32'h0,32'h0,32'hAAAABB00,32'hAABBBB00));
    foreach (tbl[i]) step(tbl[i], 1'b1);
    repeat (3) step(idle, 1'b1);

    // reset one cycle after a read is accepted; accesses during reset are ignored
    step(mk(1,0,4'h0,4'd5,32'h0, 0,0,4'h0,4'd0,32'h0, 32'h00BB00DD,32'h00BB00DD,0,0), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    flush_exp();
    drive_row(mk(1,1,4'hF,4'd5,32'hFFFFFFFF, 1,0,4'h0,4'd5,32'h0, 0,0,0,0), 1'b1);
    step(mk(1,1,4'hF,4'd5,32'hFFFFFFFF, 1,0,4'h0,4'd5,32'h0, 0,0,0,0), 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_row(idle, 1'b1);
    step(mk(1,0,4'h0,4'd5,32'h0, 1,0,4'h0,4'd5,32'h0,
            32'h00BB00DD,32'h00BB00DD,32'h00BB00DD,32'h00BB00DD), 1'b1);
    repeat (3) step(idle, 1'b1);

    // streaming reads on both ports, every cycle
    for (int i = 0; i < 16; i++)
      step(mk(1,0,4'h0,4'(i),32'h0, 1,0,4'h0,4'(15-i),32'h0, 0,0,0,0), 1'b0);
    repeat (3) step(idle, 1'b1);

    // random traffic on a narrow address range to provoke collisions and forwarding
    repeat (300) begin
      step(mk(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 4'($urandom_range(0,15)),
              4'($urandom_range(0,3)), $urandom,
              1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 4'($urandom_range(0,15)),
              4'($urandom_range(0,3)), $urandom, 0,0,0,0), 1'b0);
    end
    repeat (5) step(idle, 1'b1);

    for (int i = 0; i < 4; i++)
      cmp($sformatf("drain[%0d]", i), 32'(exp_q[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_ram_be.md
DP_RAM_BE -- requirements
Module: dp_ram_be

Interface
REQ-001 SHALL have parameter DPRAM_AW, default 4: address width; depth is 2**DPRAM_AW words.
REQ-002 SHALL have parameter DPRAM_DW, default 32: data width; only multiples of 8 are legal.
REQ-003 SHALL have parameter RD_LAT, default 1: read latency in cycles; only 1 or 2 are legal.
REQ-004 SHALL have parameter WR_PRIO, default 0: winner of a write-write byte collision; 0 = port A, 1 = port B.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have, for p in {a, b}, port cyc_p_i, input, 1 bit: access request.
REQ-008 SHALL have port we_p_i, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port be_p_i, input, DPRAM_DW/8 bits: byte enables; bit k selects byte k.
REQ-010 SHALL have port adr_p_i, input, DPRAM_AW bits: word address.
REQ-011 SHALL have port dat_p_i, input, DPRAM_DW bits: write data.
REQ-012 SHALL have port dat_p_o, output, DPRAM_DW bits: read data.
REQ-013 SHALL have port vld_p_o, output, 1 bit: read-data-valid pulse.

Function
REQ-014 SHALL treat a port as writing when cyc_p_i=1, we_p_i=1 and be_p_i != 0; at that rising edge it updates only the enabled bytes of mem[adr_p_i].
REQ-015 SHALL treat cyc_p_i=1, we_p_i=1, be_p_i=0 as a no-op: no memory change, no vld pulse.
REQ-016 SHALL accept a read when cyc_p_i=1 and we_p_i=0; be_p_i is ignored for reads, which always return the full word.
REQ-017 SHALL, on a read at port p, forward per byte: if the other port writes the same address in the same cycle, each byte enabled by that write returns the new data, and every other byte returns the pre-edge memory contents.
REQ-018 SHALL resolve a simultaneous write by both ports to the same address per byte: overlapping enabled bytes take the data of the WR_PRIO port; non-overlapping enabled bytes are written by their own port.
REQ-019 SHALL assert vld_p_o for exactly one cycle, RD_LAT rising edges after the edge that accepts the read, carrying that read's data on dat_p_o in the same cycle.
REQ-020 SHALL return, for RD_LAT=2, the data sampled in the acceptance cycle; a write in the following cycle does not alter the in-flight result.
REQ-021 SHALL hold dat_p_o at its last read value in every cycle where vld_p_o=0.
REQ-022 SHALL support back-to-back reads on every cycle on both ports with no bubbles; results are returned in issue order.
REQ-023 SHALL make the two ports fully independent apart from the forwarding (REQ-017) and collision (REQ-018) interactions.

Reset
REQ-024 SHALL, while rst_n=0, force vld_a_o=vld_b_o=0 and dat_a_o=dat_b_o=0 asynchronously, and flush all in-flight read pipeline stages.
REQ-025 SHALL ignore all writes and reads while rst_n=0.
REQ-026 SHALL NOT clear memory contents on reset; memory is initialised to zero at elaboration only.
REQ-027 SHALL never assert vld_p_o for a read accepted before or during a reset assertion.

Verification (DPRAM_DW=32, DPRAM_AW=4)
REQ-028 SHALL cover reset and first read: release reset, then read A adr 3 -> outputs are 0 during reset; vld_a_o pulses RD_LAT cycles later with dat_a_o=0x00000000.
REQ-029 SHALL cover byte-enable write: A writes adr 5, 0xAABBCCDD, be=0101; next cycle B reads adr 5 -> dat_b_o=0x00BB00DD with vld_b_o.
REQ-030 SHALL cover same-cycle forwarding: mem[2]=0; A writes adr 2, 0x11223344, be=0011 while B reads adr 2 -> dat_b_o=0x00003344.
REQ-031 SHALL cover write-write collision: WR_PRIO=0, mem[7]=0; A writes 0xAAAAAAAA be=1100 and B writes 0xBBBBBBBB be=0110 to adr 7 in the same cycle -> a later read returns 0xAAAABB00; with WR_PRIO=1 the read returns 0xAABBBB00.
REQ-032 SHALL cover reset during an in-flight read: RD_LAT=2, A reads adr 5 holding 0x00BB00DD, rst_n pulses low the next cycle -> vld_a_o is never asserted, and a read after reset still returns 0x00BB00DD.
REQ-033 SHALL cover streaming reads: RD_LAT=2, A reads adr 0..15 on consecutive cycles -> vld_a_o stays high for 16 cycles starting 2 cycles after the first read, with data in address order.
